// File: rtl/binary2decimal_decoder.sv
// binary2decimal_decoder
//   Buffered 4-bit binary to 10-bit one-hot decimal decoder. Codes arrive on
//   a valid/ready handshake and wait in a DEPTH-entry FIFO. The head entry is
//   decoded combinationally. Codes 10..15 are queued like any other code,
//   flagged at the head and counted at push time.
//
//   Handshake rule (both ports): a transfer happens on a rising clk edge
//   where valid && ready are both high. Ready never depends on the valid of
//   the same port, and valid never depends on the ready of the same port.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   producer has a code on binary
//   in_ready   FIFO not full
//   binary     4-bit code to enqueue
//   out_valid  FIFO not empty; decimal/out_err describe the head entry
//   out_ready  consumer takes the head entry
//   decimal    one-hot decode of the head code; 0 if invalid or empty
//   out_err    head code is 10..15; 0 if empty
//   flush      synchronous discard of all queued entries
//   level      occupancy 0..DEPTH
//   err_count  saturating count of accepted invalid codes
module binary2decimal_decoder #(
  parameter int DEPTH = 4,
  parameter int ECW   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               binary,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [9:0]               decimal,
  output logic                     out_err,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic [ECW-1:0]           err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [ECW-1:0] r_err_count;

  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_in_invalid;
  logic [3:0] w_head;

  // A push is gated only by full, never by a same-cycle pop. Flush wins over
  // both transfers in its cycle.
  assign w_full       = (r_level == LW'(DEPTH));
  assign w_empty      = (r_level == '0);
  assign w_push       = in_valid && !w_full && !flush;
  assign w_pop        = out_ready && !w_empty && !flush;
  assign w_in_invalid = (binary > 4'd9);
  assign w_head       = r_mem[r_rd_ptr];

  // Storage carries no reset: stale contents are masked by level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= binary;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Counts at push time, so an invalid code discarded by flush in the same
  // cycle is never counted. Holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_push && w_in_invalid && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ECW'(1);
    end
  end

  // Head decode sees only the registered entry, so there is no
  // same-cycle bypass from binary to decimal.
  always_comb begin
    decimal = '0;
    out_err = 1'b0;
    if (!w_empty) begin
      if (w_head > 4'd9) begin
        out_err = 1'b1;
      end else begin
        decimal = 10'(1) << w_head;
      end
    end
  end

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign level     = r_level;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_binary2decimal_decoder.sv
module tb_binary2decimal_decoder;

  localparam int DEPTH = 4;
  localparam int ECW   = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     binary;
  logic           out_valid;
  logic           out_ready;
  logic [9:0]     decimal;
  logic           out_err;
  logic           flush;
  logic [LW-1:0]  level;
  logic [ECW-1:0] err_count;

  always #5 clk = ~clk;

  binary2decimal_decoder #(.DEPTH(DEPTH), .ECW(ECW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .binary    (binary),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .decimal   (decimal),
    .out_err   (out_err),
    .flush     (flush),
    .level     (level),
    .err_count (err_count)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {out_err, decimal}
  logic [10:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: the negedge before an accepting edge sees stable handshake signals.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL monitor_unexpected: got err=%0d dec=%0d with empty expected queue",
                 out_err, decimal);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        tests++;
        if ({out_err, decimal} !== e) begin
          fails++;
          $display("FAIL monitor_head: got err=%0d dec=%0d expected err=%0d dec=%0d",
                   out_err, decimal, e[10], e[9:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a code for one edge; the caller knows it will be accepted.
  task automatic push1(input logic [3:0] code, input logic [9:0] e_dec, input logic e_err);
    in_valid = 1'b1;
    binary   = code;
    exp_q.push_back({e_err, e_dec});
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (level != '0 && n < 20) begin
      cycle();
      n++;
    end
    check("drain_level", 32'(level), 32'd0);
  endtask

  logic [9:0] sweep_exp [10] = '{10'd1, 10'd2, 10'd4, 10'd8, 10'd16,
                                 10'd32, 10'd64, 10'd128, 10'd256, 10'd512};
  logic [1:0] sat_exp [4] = '{2'd2, 2'd3, 2'd3, 2'd3};

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; binary = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset values before any clock edge
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_decimal", 32'(decimal), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    cycle();
    cycle();
    rst = 1'b0;

    // Valid sweep at full rate, one-cycle latency, level stays 1
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      binary   = 4'(c);
      exp_q.push_back({1'b0, sweep_exp[c]});
      cycle();
      check("sweep_decimal", 32'(decimal), 32'(sweep_exp[c]));
      check("sweep_out_err", 32'(out_err), 32'd0);
      check("sweep_level", 32'(level), 32'd1);
    end
    in_valid = 1'b0;
    drain();
    check("sweep_err_count", 32'(err_count), 32'd0);

    // Invalid code followed by a valid one
    in_valid = 1'b1;
    binary = 4'd12;
    exp_q.push_back({1'b1, 10'd0});
    cycle();
    check("inv12_decimal", 32'(decimal), 32'd0);
    check("inv12_out_err", 32'(out_err), 32'd1);
    binary = 4'd3;
    exp_q.push_back({1'b0, 10'd8});
    cycle();
    in_valid = 1'b0;
    check("after3_decimal", 32'(decimal), 32'd8);
    check("after3_out_err", 32'(out_err), 32'd0);
    check("inv_err_count", 32'(err_count), 32'd1);
    drain();

    // Full and backpressure
    out_ready = 1'b0;
    push1(4'd5, 10'd32, 1'b0);
    push1(4'd6, 10'd64, 1'b0);
    push1(4'd7, 10'd128, 1'b0);
    push1(4'd8, 10'd256, 1'b0);
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    binary = 4'd9;
    cycle();
    cycle();
    check("full_hold_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    cycle();
    check("full_pop_only_level", 32'(level), 32'd3);
    check("full_pop_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back({1'b0, 10'd512});
    cycle();
    in_valid = 1'b0;
    check("full_pushpop_level", 32'(level), 32'd3);
    drain();

    // Simultaneous push and pop at level 2
    out_ready = 1'b0;
    push1(4'd1, 10'd2, 1'b0);
    push1(4'd2, 10'd4, 1'b0);
    check("sim_level_pre", 32'(level), 32'd2);
    in_valid = 1'b1;
    binary = 4'd3;
    exp_q.push_back({1'b0, 10'd8});
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("sim_level_post", 32'(level), 32'd2);
    drain();

    // Flush alongside an invalid push: nothing kept, nothing counted
    out_ready = 1'b0;
    push1(4'd4, 10'd16, 1'b0);
    push1(4'd5, 10'd32, 1'b0);
    push1(4'd6, 10'd64, 1'b0);
    check("flush_level_pre", 32'(level), 32'd3);
    flush = 1'b1;
    in_valid = 1'b1;
    binary = 4'd13;
    exp_q.delete();
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_err_count", 32'(err_count), 32'd1);

    // Saturation of a 2-bit error counter
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push1(4'd15, 10'd0, 1'b1);
      check("sat_err_count", 32'(err_count), 32'(sat_exp[i]));
    end
    drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    push1(4'd7, 10'd128, 1'b0);
    push1(4'd8, 10'd256, 1'b0);
    check("mid_level_pre", 32'(level), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_decimal", 32'(decimal), 32'd0);
    check("mid_rst_out_err", 32'(out_err), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    exp_q.delete();
    #1;
    rst = 1'b0;
    cycle();
    out_ready = 1'b1;
    push1(4'd0, 10'd1, 1'b0);
    check("post_rst_out_valid", 32'(out_valid), 32'd1);
    check("post_rst_decimal", 32'(decimal), 32'd1);
    drain();
    cycle();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/binary2decimal_decoder.md
# binary2decimal_decoder

Buffered 4-bit binary to 10-bit one-hot decimal decoder. It is the receive-side counterpart of the decimal-to-binary encoder. Binary codes enter through a valid/ready handshake and are queued in a small FIFO. Each code is presented at the output as a one-hot decimal word, with codes outside 0..9 flagged and counted.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- ECW, 8, width of the invalid-code counter
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer has a code on `binary`
- in_ready  output  1  decoder can accept; equals !full
- binary  input  4  binary code to decode
- out_valid  output  1  `decimal`/`out_err` hold a queued result; equals !empty
- out_ready  input  1  consumer takes the head entry
- decimal  output  10  one-hot decode of the head code (bit n set for code n); 0 for invalid code or empty
- out_err  output  1  head code is 10..15; 0 when empty
- flush  input  1  synchronous: discard all queued entries
- level  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH
- err_count  output  ECW  saturating count of accepted invalid codes

## Operation
- Push when in_valid && in_ready: store `binary` at the write pointer and increment wr_ptr (wraps mod DEPTH).
- Pop when out_valid && out_ready: increment rd_ptr (wraps mod DEPTH).
- level: +1 on push only, -1 on pop only, unchanged when both occur.
- in_ready = (level != DEPTH). A push is never allowed when full, even if a pop occurs in the same cycle.
- out_valid = (level != 0). There is no bypass: a code pushed into an empty FIFO is not visible in the same cycle.
- decimal and out_err are decoded combinationally from the registered head entry only, not from `binary`. They are forced to 0 when empty.
- Invalid codes (10..15) are accepted and queued like valid ones. At the head they give decimal=0 and out_err=1.
- err_count increments on each push of an invalid code. It saturates at 2^ECW-1 and never wraps.
- flush: at the next edge, wr_ptr=rd_ptr=0 and level=0. A push or pop in the same cycle is ignored. err_count is not affected, including any increment that cycle.
- rst (async): wr_ptr=rd_ptr=0, level=0, err_count=0. Storage contents are don't-care.

## Timing
- Reset values of outputs: in_ready=1, out_valid=0, decimal=0, out_err=0, level=0, err_count=0. These values are reached immediately on rst assertion, without waiting for a clock.
- Latency: a code pushed at edge k into an empty FIFO gives out_valid=1 and its decode in the cycle after edge k (1 cycle).
- Throughput: one push and one pop per cycle. With out_ready held high, a stream sustains full rate at level 1.
- in_ready drops in the cycle after the push that reaches level=DEPTH. It rises in the cycle after the first pop from full.
- err_count updates at the same edge as the push, so its new value is visible the following cycle.
- Reset asserted mid-stream: all queued entries are lost and outputs take reset values asynchronously. After deassertion, the first push behaves as into an empty FIFO.
- Output ordering is strict FIFO. No entry is dropped except by flush or rst.

## Test plan
- Reset check: assert rst with no clock edge. Required: in_ready=1, out_valid=0, decimal=0, out_err=0, level=0, err_count=0.
- Valid sweep: push codes 0..9 with out_ready=1. Required: decimal sequence 1,2,4,8,16,32,64,128,256,512, one per cycle, each 1 cycle after its push, out_err=0 throughout, err_count=0.
- Invalid codes: push 12 then 3. Required: first output decimal=0, out_err=1. Second output decimal=8, out_err=0. err_count=1. Then push 15 repeatedly with ECW=2. Required: err_count stops at 3.
- Full/backpressure: out_ready=0, push 5,6,7,8 (DEPTH=4). Required: level=4 and in_ready=0. A fifth push of 9 with in_valid held is not accepted. Raise out_ready: outputs appear as 32,64,128,256, then 9 is accepted.
- Simultaneous push/pop: at level=2 push and pop in the same cycle. Required: level stays 2 and order is preserved. At level=4 with out_ready=1 and in_valid=1: only the pop occurs, and level becomes 3.
- Flush and async reset mid-stream: with level=3, assert flush for one cycle alongside a push. Required: level=0 and out_valid=0 next cycle, err_count unchanged. Then refill 2 entries and pulse rst between edges. Required: immediate reset values, and the next push 0 yields decimal=1 one cycle later.
